buzzer_tone_gen: RTL and testbench
==================================

// Module: buzzer_tone_gen
// PURPOSE
//   Converts the 4-bit note index from the auto/free-play song sequencers into a
//   square wave for the board's passive buzzer. Sits directly downstream of the
//   song player and drives the buzzer pin. Index 0 is a rest; 1..15 select pitches.
// PARAMETERS
//   CLK_HZ   100_000_000  system clock frequency; sets every half-period constant
//   CNT_W    20           half-period counter width; must hold CLK_HZ/(2*262)
// PORTS
//   clk        in   1      system clock
//   rst_n      in   1      synchronous reset, active-low
//   en         in   1      1 = sound allowed; 0 = mute and hold phase at zero
//   note_in    in   4      note index from the sequencer (0 = rest)
//   vol        in   2      volume level; present only with BUZZER_VOL_EN
//   buzzer     out  1      square-wave drive to the buzzer pin
//   playing    out  1      1 while a non-rest note is sounding (en & cur_note!=0)
// BEHAVIOUR
//   - Note map: 1..7 = C4 D4 E4 F4 G4 A4 B4 (262 294 330 349 392 440 494 Hz);
//     8..14 = C5..B5 (523 587 659 698 784 880 988 Hz); 15 = C6 (1047 Hz).
//   - half = CLK_HZ/(2*f), integer division, truncated; rest => half unused.
//   - Registers: cur_note[3:0], cnt[CNT_W-1:0], tone. Reset: all 0; buzzer=0, playing=0.
//   - Priority per clk edge: (1) !rst_n -> reset; (2) note_in!=cur_note ->
//     cur_note<=note_in, cnt<=0, tone<=0; (3) !en or cur_note==0 -> cnt<=0, tone<=0;
//     (4) cnt==half-1 -> cnt<=0, tone<=~tone; (5) else cnt<=cnt+1.
//   - Latency: note change sampled at edge N forces tone=0 after N; first rising
//     edge of tone after edge N+half; full period = 2*half cycles thereafter.
//   - Same note held across sequencer steps: no phase restart (no glitch).
//   - en falling mid-period: tone to 0 next edge; en rising restarts at phase 0.
//   - Reset mid-note: output 0 next edge; resumes only after note_in differs from 0.
//   - buzzer and playing are registered outputs (no combinational path from inputs).
//   - cnt never exceeds half-1; wrap is to exactly 0.
// CONFIGURATION
//   BUZZER_VOL_EN defined: adds vol port and free-running 2-bit pwm_cnt (reset 0,
//     incrementing every clk, wraps 3->0); buzzer = tone & (pwm_cnt <= vol), i.e.
//     duty of high phase 25/50/75/100 % for vol 0/1/2/3; still registered.
//   Not defined: no vol port, no pwm_cnt; buzzer = tone.
// STRUCTURE
//   Package buzzer_pkg: NOTE_REST=4'd0, note index constants, frequency table,
//     function half_period(note, clk_hz) returning CNT_W-bit constants.
//   Sub-module note_period_lut: combinational ROM note index -> half-period.
//   Top holds the sequential divider, change detect and optional PWM gate.
// TESTING (bench uses CLK_HZ=1_000_000)
//   - Reset held 5 cycles with note_in=6, en=1 -> buzzer=0, playing=0 throughout.
//   - note_in=6 (A4) steady, en=1 -> half=1136; buzzer toggles every 1136 cycles,
//     first rise 1136 cycles after the sampling edge; playing=1.
//   - note_in 1 -> 15 mid-high-phase -> buzzer 0 next cycle, then period 2*477.
//   - note_in=0 -> buzzer stuck 0, playing=0; note_in=1 -> half=1908 restart.
//   - en dropped for 300 cycles mid-note -> buzzer 0, cnt 0; re-enable -> fresh
//     phase, first rise 1136 cycles later; holding same note 10k cycles: no jitter.
//   - BUZZER_VOL_EN, note 6, vol=0 -> high phase shows 1-of-4 duty; vol=3 -> solid.

Source files
------------

// File: rtl/buzzer_pkg.sv
// -----------------------------------------------------------------------------
// buzzer_pkg
//   Shared definitions for the buzzer tone generator. It holds the note index
//   names, the pitch table in Hz and a helper that turns a note into its
//   half-period in clock cycles.
//   Index 0 is a rest. Indices 1..15 run from C4 up to C6.
// -----------------------------------------------------------------------------
package buzzer_pkg;

  typedef enum logic [3:0] {
    NOTE_REST = 4'd0,
    NOTE_C4   = 4'd1,
    NOTE_D4   = 4'd2,
    NOTE_E4   = 4'd3,
    NOTE_F4   = 4'd4,
    NOTE_G4   = 4'd5,
    NOTE_A4   = 4'd6,
    NOTE_B4   = 4'd7,
    NOTE_C5   = 4'd8,
    NOTE_D5   = 4'd9,
    NOTE_E5   = 4'd10,
    NOTE_F5   = 4'd11,
    NOTE_G5   = 4'd12,
    NOTE_A5   = 4'd13,
    NOTE_B5   = 4'd14,
    NOTE_C6   = 4'd15
  } note_e;

  // Pitch in Hz, indexed by note. Entry 0 (rest) has no pitch.
  localparam int unsigned NOTE_FREQ_HZ [16] = '{
    0,   262, 294, 330, 349, 392, 440, 494,
    523, 587, 659, 698, 784, 880, 988, 1047
  };

  // Returns the number of clock cycles in half a period of the note, rounded
  // down. A rest returns 0; the divider never uses the half-period of a rest.
  function automatic int unsigned half_period(input logic [3:0] note,
                                              input int unsigned clk_hz);
    if (note == NOTE_REST) return 0;
    return clk_hz / (2 * NOTE_FREQ_HZ[note]);
  endfunction

endpackage

// File: rtl/note_period_lut.sv
// -----------------------------------------------------------------------------
// note_period_lut
//   Combinational ROM that maps a note index to its half-period in clock
//   cycles. All 16 entries are elaboration-time constants, so no divider is
//   built in hardware.
// Ports
//   note_i  in  4      note index (0 = rest)
//   half_o  out CNT_W  half-period in clock cycles (0 for a rest)
// -----------------------------------------------------------------------------
module note_period_lut
  import buzzer_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int          CNT_W  = 20
) (
  input  logic [3:0]       note_i,
  output logic [CNT_W-1:0] half_o
);

  logic [CNT_W-1:0] rom [16];

  for (genvar i = 0; i < 16; i++) begin : g_rom
    assign rom[i] = CNT_W'(half_period(4'(i), CLK_HZ));
  end

  assign half_o = rom[note_i];

endmodule

// File: rtl/buzzer_tone_gen.sv
// -----------------------------------------------------------------------------
// buzzer_tone_gen
//   Converts the sequencer's 4-bit note index into a square wave that drives
//   the passive buzzer. A change in the note restarts the phase at zero. When
//   the same note is held, the phase continues without a break. Muting, or a
//   rest, holds the phase at zero.
// Ports
//   clk      in   1  system clock
//   rst_n    in   1  synchronous reset, active low
//   en       in   1  1 = sound allowed, 0 = mute and hold phase at zero
//   note_in  in   4  note index from the sequencer (0 = rest)
//   vol      in   2  volume level (only when BUZZER_VOL_EN is defined)
//   buzzer   out  1  registered square-wave drive
//   playing  out  1  registered; 1 while a non-rest note is sounding
// Configuration
//   BUZZER_VOL_EN  adds the vol port. A free-running 2-bit PWM gates the high
//                  phase to a duty of 25/50/75/100 % for vol = 0/1/2/3.
// -----------------------------------------------------------------------------
module buzzer_tone_gen
  import buzzer_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int          CNT_W  = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] note_in,
`ifdef BUZZER_VOL_EN
  input  logic [1:0] vol,
`endif
  output logic       buzzer,
  output logic       playing
);

  logic [3:0]       cur_note_q, cur_note_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half;
  logic             tone_q, tone_d;
  logic             playing_q, playing_d;

  // The half-period follows the registered note, so the table lookup stays
  // off the path from note_in.
  note_period_lut #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (CNT_W)
  ) u_lut (
    .note_i (cur_note_q),
    .half_o (half)
  );

  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a latch.
    cur_note_d = cur_note_q;
    cnt_d      = cnt_q + CNT_W'(1);
    tone_d     = tone_q;
    if (note_in != cur_note_q) begin
      // A new note always starts at phase 0, even when sound is muted.
      cur_note_d = note_in;
      cnt_d      = '0;
      tone_d     = 1'b0;
    end else if (!en || cur_note_q == NOTE_REST) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (cnt_q == half - CNT_W'(1)) begin
      cnt_d  = '0;
      tone_d = ~tone_q;
    end
    // playing is computed from the next note, so it changes in the same cycle as tone.
    playing_d = en && (cur_note_d != NOTE_REST);
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge. Sequential state uses
    // non-blocking assignments only.
    if (!rst_n) begin
      cur_note_q <= NOTE_REST;
      cnt_q      <= '0;
      tone_q     <= 1'b0;
      playing_q  <= 1'b0;
    end else begin
      cur_note_q <= cur_note_d;
      cnt_q      <= cnt_d;
      tone_q     <= tone_d;
      playing_q  <= playing_d;
    end
  end

`ifdef BUZZER_VOL_EN
  logic [1:0] pwm_q, pwm_d;
  logic       buzzer_q, buzzer_d;

  // Gating uses the next values of tone and the PWM count. The output
  // register therefore gives the same timing as the ungated build.
  assign pwm_d    = pwm_q + 2'd1;
  assign buzzer_d = tone_d & (pwm_d <= vol);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_q    <= 2'd0;
      buzzer_q <= 1'b0;
    end else begin
      pwm_q    <= pwm_d;
      buzzer_q <= buzzer_d;
    end
  end

  assign buzzer = buzzer_q;
`else
  assign buzzer = tone_q;
`endif

  assign playing = playing_q;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// -----------------------------------------------------------------------------
// tb_buzzer_tone_gen
//   Self-checking bench for buzzer_tone_gen at CLK_HZ = 1 MHz. The reference
//   model counts the cycles since the current phase began. The expected tone
//   is (cycles / half) mod 2, where half is computed from the pitch table in Hz.
//   Define BUZZER_VOL_EN to also exercise the volume gate.
// -----------------------------------------------------------------------------
module tb_buzzer_tone_gen;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int FREQ [16] = '{
    0,   262, 294, 330, 349, 392, 440, 494,
    523, 587, 659, 698, 784, 880, 988, 1047
  };

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       en      = 1'b0;
  logic [3:0] note_in = 4'd0;
`ifdef BUZZER_VOL_EN
  logic [1:0] vol     = 2'd3;
`endif
  logic       buzzer;
  logic       playing;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state
  int m_note = 0;
  int m_k    = 0;
  int m_pwm  = 0;
  bit exp_buzzer  = 1'b0;
  bit exp_playing = 1'b0;

  buzzer_tone_gen #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (20)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .note_in (note_in),
`ifdef BUZZER_VOL_EN
    .vol     (vol),
`endif
    .buzzer  (buzzer),
    .playing (playing)
  );

  always #5 clk = ~clk;

  function automatic int half_of(input int note);
    return CLK_HZ / (2 * FREQ[note]);
  endfunction

  // Advance one clock. Update the model from the inputs sampled at the edge,
  // then return at the falling edge, when the DUT outputs have settled.
  task automatic tick();
    bit tone;
    @(posedge clk);
    if (!rst_n) begin
      m_note = 0;
      m_k    = 0;
      m_pwm  = 0;
    end else begin
      if (int'(note_in) != m_note) begin
        m_note = int'(note_in);
        m_k    = 0;
      end else if (!en || m_note == 0) begin
        m_k = 0;
      end else begin
        m_k++;
      end
      m_pwm = (m_pwm + 1) % 4;
    end
    exp_playing = rst_n && en && (m_note != 0);
    tone = (m_note != 0) && (((m_k / half_of(m_note)) % 2) == 1);
`ifdef BUZZER_VOL_EN
    exp_buzzer = tone && (m_pwm <= int'(vol));
`else
    exp_buzzer = tone;
`endif
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    note_in = 4'd6;
    en      = 1'b1;
    repeat (5) begin
      tick();
      n_cmp++;
      if (buzzer !== 1'b0 || playing !== 1'b0) begin
        n_bad++;
        $display("FAIL reset cyc=%0d buzzer=%b playing=%b expected 0/0", cyc, buzzer, playing);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_a4_steady();
    int rise = -1;
    for (int i = 0; i < 4 * 1136 + 20; i++) begin
      tick();
      n_cmp++;
      if (buzzer !== exp_buzzer || playing !== exp_playing) begin
        n_bad++;
        $display("FAIL a4_model cyc=%0d buzzer=%b playing=%b expected %b/%b",
                 cyc, buzzer, playing, exp_buzzer, exp_playing);
      end
      if (rise < 0 && buzzer === 1'b1) rise = i;
    end
    n_cmp++;
    if (rise !== 1136) begin
      n_bad++;
      $display("FAIL a4_first_rise got=%0d expected 1136", rise);
    end
    n_cmp++;
    if (playing !== 1'b1) begin
      n_bad++;
      $display("FAIL a4_playing got=%b expected 1", playing);
    end
  endtask

  task automatic test_note_change();
    int t;
    note_in = 4'd1;
    t = 0;
    do begin
      tick(); t++;
      n_cmp++;
      if (buzzer !== exp_buzzer) begin
        n_bad++;
        $display("FAIL c4_model cyc=%0d buzzer=%b expected %b", cyc, buzzer, exp_buzzer);
      end
    end while (buzzer !== 1'b1 && t < 5000);
    n_cmp++;
    if (t !== 1909) begin
      n_bad++;
      $display("FAIL c4_first_rise got=%0d expected 1909", t);
    end
    // Switch notes somewhere inside the high phase.
    repeat ($urandom_range(1, 1800)) tick();
    note_in = 4'd15;
    tick();
    n_cmp++;
    if (buzzer !== 1'b0) begin
      n_bad++;
      $display("FAIL c6_change_low got=%b expected 0", buzzer);
    end
    t = 0;
    do begin tick(); t++; end while (buzzer !== 1'b1 && t < 3000);
    n_cmp++;
    if (t !== 477) begin
      n_bad++;
      $display("FAIL c6_first_rise got=%0d expected 477", t);
    end
    t = 0;
    do begin tick(); t++; end while (buzzer === 1'b1 && t < 3000);
    n_cmp++;
    if (t !== 477) begin
      n_bad++;
      $display("FAIL c6_high_len got=%0d expected 477", t);
    end
    t = 0;
    do begin tick(); t++; end while (buzzer !== 1'b1 && t < 3000);
    n_cmp++;
    if (t !== 477) begin
      n_bad++;
      $display("FAIL c6_low_len got=%0d expected 477", t);
    end
  endtask

  task automatic test_rest();
    int t;
    note_in = 4'd0;
    repeat (500) begin
      tick();
      n_cmp++;
      if (buzzer !== 1'b0 || playing !== 1'b0) begin
        n_bad++;
        $display("FAIL rest cyc=%0d buzzer=%b playing=%b expected 0/0", cyc, buzzer, playing);
      end
    end
    note_in = 4'd1;
    t = 0;
    do begin tick(); t++; end while (buzzer !== 1'b1 && t < 5000);
    n_cmp++;
    if (t !== 1909) begin
      n_bad++;
      $display("FAIL rest_restart_rise got=%0d expected 1909", t);
    end
  endtask

  task automatic test_en_drop();
    int t;
    int last;
    note_in = 4'd6;
    repeat ($urandom_range(1500, 3000)) tick();
    en = 1'b0;
    repeat (300) begin
      tick();
      n_cmp++;
      if (buzzer !== 1'b0 || playing !== 1'b0) begin
        n_bad++;
        $display("FAIL en_low cyc=%0d buzzer=%b playing=%b expected 0/0", cyc, buzzer, playing);
      end
    end
    en = 1'b1;
    // t counts edges from the re-enable edge, which is one cycle after the
    // last muted edge.
    t = 0;
    do begin tick(); t++; end while (buzzer !== 1'b1 && t < 3000);
    n_cmp++;
    if (t !== 1136) begin
      n_bad++;
      $display("FAIL en_restart_rise got=%0d expected 1136", t);
    end
    // Hold the same note for a long time; every toggle interval stays at 1136.
    last = 0;
    for (int i = 1; i <= 10000; i++) begin
      logic prev;
      prev = buzzer;
      tick();
      n_cmp++;
      if (buzzer !== exp_buzzer) begin
        n_bad++;
        $display("FAIL hold_model cyc=%0d buzzer=%b expected %b", cyc, buzzer, exp_buzzer);
      end
      if (buzzer !== prev) begin
        n_cmp++;
        if (i - last !== 1136) begin
          n_bad++;
          $display("FAIL hold_jitter interval=%0d expected 1136", i - last);
        end
        last = i;
      end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    note_in = 4'd6;
    rst_n   = 1'b0;
    tick();
    n_cmp++;
    if (buzzer !== 1'b0 || playing !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid buzzer=%b playing=%b expected 0/0", buzzer, playing);
    end
    repeat (2) tick();
    note_in = 4'd0;
    rst_n   = 1'b1;
    repeat (300) begin
      tick();
      n_cmp++;
      if (buzzer !== 1'b0 || playing !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_hold cyc=%0d buzzer=%b playing=%b expected 0/0", cyc, buzzer, playing);
      end
    end
    note_in = 4'd6;
    t = 0;
    do begin tick(); t++; end while (buzzer !== 1'b1 && t < 3000);
    n_cmp++;
    if (t !== 1137) begin
      n_bad++;
      $display("FAIL rst_resume_rise got=%0d expected 1137", t);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 12; s++) begin
      note_in = 4'($urandom_range(0, 15));
      en      = ($urandom_range(0, 3) != 0);
`ifdef BUZZER_VOL_EN
      vol     = 2'($urandom_range(0, 3));
`endif
      repeat ($urandom_range(1, 1500)) begin
        tick();
        n_cmp++;
        if (buzzer !== exp_buzzer || playing !== exp_playing) begin
          n_bad++;
          $display("FAIL random seg=%0d cyc=%0d note=%0d en=%b buzzer=%b playing=%b expected %b/%b",
                   s, cyc, note_in, en, buzzer, playing, exp_buzzer, exp_playing);
        end
      end
    end
  endtask

`ifdef BUZZER_VOL_EN
  task automatic test_vol();
    int ones;
    en      = 1'b1;
    note_in = 4'd0;
    tick();
    note_in = 4'd6;
    vol     = 2'd0;
    ones    = 0;
    // Two full periods; with vol 0 only one cycle in four of each high phase is set.
    repeat (4 * 1136 + 1) begin
      tick();
      n_cmp++;
      if (buzzer !== exp_buzzer) begin
        n_bad++;
        $display("FAIL vol0_model cyc=%0d buzzer=%b expected %b", cyc, buzzer, exp_buzzer);
      end
      if (buzzer === 1'b1) ones++;
    end
    n_cmp++;
    if (ones !== 568) begin
      n_bad++;
      $display("FAIL vol0_duty ones=%0d expected 568", ones);
    end
    vol  = 2'd3;
    ones = 0;
    repeat (4 * 1136) begin
      tick();
      if (buzzer === 1'b1) ones++;
    end
    n_cmp++;
    if (ones !== 2272) begin
      n_bad++;
      $display("FAIL vol3_duty ones=%0d expected 2272", ones);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_a4_steady();
    test_note_change();
    test_rest();
    test_en_drop();
    test_reset_mid();
`ifdef BUZZER_VOL_EN
    test_vol();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
